// File: rtl/seq_divider_32.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned.
// Sign handling is done by dividing magnitudes and fixing signs in a final cycle.
module seq_divider_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WIDTH-1:0]  p_q, p_d;        // partial remainder
    logic [WIDTH-1:0]  a_q, a_d;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]  dvs_q, dvs_d;    // divisor magnitude
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div_zero_q, div_zero_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;

    logic [WIDTH:0]    p_shift;
    logic [WIDTH:0]    trial;
    logic [WIDTH-1:0]  abs_dvd;
    logic [WIDTH-1:0]  abs_dvs;

    // Next-state logic: operand capture, one restoring step per RUN cycle, sign fix-up.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        p_d         = p_q;
        a_d         = a_q;
        dvs_d       = dvs_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        div_zero_d  = div_zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        abs_dvd = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        abs_dvs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        // P stays below the divisor, so WIDTH bits hold it between steps.
        p_shift = {p_q, a_q[WIDTH-1]};
        trial   = p_shift - {1'b0, dvs_q};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                        state_d     = StDone;
                    end else begin
                        div_zero_d = 1'b0;
                        a_d        = abs_dvd;
                        dvs_d      = abs_dvs;
                        p_d        = '0;
                        neg_q_d    = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_d    = is_signed & dividend[WIDTH-1];
                        count_d    = '0;
                        state_d    = StRun;
                    end
                end
            end
            StRun: begin
                if (!trial[WIDTH]) begin
                    p_d = trial[WIDTH-1:0];
                    a_d = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d = p_shift[WIDTH-1:0];
                    a_d = {a_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                quotient_d  = neg_q_q ? -a_q : a_q;
                remainder_d = neg_r_q ? -p_q : p_q;
                state_d     = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StRun) || (state_d == StFix);
        done_d = (state_d == StDone);
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            p_q         <= '0;
            a_q         <= '0;
            dvs_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            p_q         <= p_d;
            a_q         <= a_d;
            dvs_q       <= dvs_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule
